// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants, chunk derivation and stage control record for pipelined_adder
package adder_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    // Control part of one stage register; data fields are sized by the top's parameters.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

endpackage

// File: rtl/rca_slice.sv
// rtl/rca_slice.sv - combinational CW-bit ripple-carry adder slice built from full-adder equations
module rca_slice
    import adder_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout
);

    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < CW; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - STAGES-deep pipelined ripple adder/subtractor with valid/ready on both sides
// Optional signed-overflow output enabled by defining PIPE_ADDER_OVF_EN.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef PIPE_ADDER_OVF_EN
    output logic [WIDTH:0]   sum,
    output logic             ovf
`else
    output logic [WIDTH:0]   sum
`endif
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be divisible by STAGES and STAGES >= 1");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    // Per-stage inputs: element k is what stage k sees this cycle.
    logic [WIDTH-1:0] w_a     [STAGES];
    logic [WIDTH-1:0] w_b     [STAGES];
    logic [WIDTH-1:0] w_psum  [STAGES];
    logic [WIDTH-1:0] w_nsum  [STAGES];
    stage_ctl_t       w_ctl_in[STAGES];
    logic [CHUNK-1:0] w_s     [STAGES];
    logic             w_co    [STAGES];

    stage_ctl_t       r_ctl [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];

`ifdef PIPE_ADDER_OVF_EN
    logic w_sa [STAGES];
    logic w_sb [STAGES];
    logic r_sa [STAGES];
    logic r_sb [STAGES];
`endif

    assign w_b_eff   = sub ? ~b : b;
    assign w_c0      = sub ? 1'b1 : cin;
    assign out_valid = r_ctl[STAGES-1].valid;
    assign w_adv     = out_ready | ~out_valid;
    assign in_ready  = w_adv;
    assign sum       = {r_ctl[STAGES-1].carry, r_sum[STAGES-1]};

    always_comb begin
        w_a[0]      = a;
        w_b[0]      = w_b_eff;
        w_psum[0]   = '0;
        w_ctl_in[0] = '{valid: in_valid, carry: w_c0};
`ifdef PIPE_ADDER_OVF_EN
        w_sa[0]     = a[WIDTH-1];
        w_sb[0]     = w_b_eff[WIDTH-1];
`endif
        for (int k = 1; k < STAGES; k++) begin
            w_a[k]      = r_a[k-1];
            w_b[k]      = r_b[k-1];
            w_psum[k]   = r_sum[k-1];
            w_ctl_in[k] = r_ctl[k-1];
`ifdef PIPE_ADDER_OVF_EN
            w_sa[k]     = r_sa[k-1];
            w_sb[k]     = r_sb[k-1];
`endif
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        rca_slice #(.CW(CHUNK)) u_rca (
            .a    (w_a[k][k*CHUNK +: CHUNK]),
            .b    (w_b[k][k*CHUNK +: CHUNK]),
            .cin  (w_ctl_in[k].carry),
            .sum  (w_s[k]),
            .cout (w_co[k])
        );
    end

    // Completed lower chunks ride along; stage k fills in chunk k.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_nsum[k]                    = w_psum[k];
            w_nsum[k][k*CHUNK +: CHUNK]  = w_s[k];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                r_ctl[k] <= '0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
`ifdef PIPE_ADDER_OVF_EN
                r_sa[k]  <= 1'b0;
                r_sb[k]  <= 1'b0;
`endif
            end
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_ctl[k] <= '{valid: w_ctl_in[k].valid, carry: w_co[k]};
                r_a[k]   <= w_a[k];
                r_b[k]   <= w_b[k];
                r_sum[k] <= w_nsum[k];
`ifdef PIPE_ADDER_OVF_EN
                r_sa[k]  <= w_sa[k];
                r_sb[k]  <= w_sb[k];
`endif
            end
        end
    end

`ifdef PIPE_ADDER_OVF_EN
    assign ovf = (r_sa[STAGES-1] == r_sb[STAGES-1]) &
                 (r_sum[STAGES-1][WIDTH-1] != r_sa[STAGES-1]);
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - directed self-checking bench for pipelined_adder (16/4 and 8/1 builds)
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, out_ready, cin, sub;
    logic [15:0] a, b;
    logic        in_ready, out_valid;
    logic [16:0] sum;
    logic        ovf;

    logic        in_valid8, out_ready8, cin8, sub8;
    logic [7:0]  a8, b8;
    logic        in_ready8, out_valid8;
    logic [8:0]  sum8;
    logic        ovf8;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef PIPE_ADDER_OVF_EN
        .sum(sum), .ovf(ovf)
`else
        .sum(sum)
`endif
    );

    pipelined_adder #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8),
`ifdef PIPE_ADDER_OVF_EN
        .sum(sum8), .ovf(ovf8)
`else
        .sum(sum8)
`endif
    );

`ifndef PIPE_ADDER_OVF_EN
    assign ovf  = 1'b0;
    assign ovf8 = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                           input logic ts, input logic [16:0] es, input logic eo, input string tag);
        int lat;
        a = ta; b = tb_v; cin = tc; sub = ts;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 4);
        check({tag, "_sum"}, sum, es);
`ifdef PIPE_ADDER_OVF_EN
        check({tag, "_ovf"}, ovf, eo);
`endif
    endtask

    initial begin
        logic [16:0] held;
        int          issued, rcv, extra;
        logic        acc;

        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_in_ready", in_ready, 1);
`ifdef PIPE_ADDER_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        tick();
        reset = 1'b0;
        tick();

        run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h1_0000, 1'b0, "add_ffff_1");
        run_one(16'h0FFF, 16'h0000, 1'b1, 1'b0, 17'h0_1000, 1'b0, "add_cin_ripple");
        run_one(16'h1234, 16'h4321, 1'b0, 1'b0, 17'h0_5555, 1'b0, "add_plain");
        run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h0_8000, 1'b1, "add_signed_ovf");
        run_one(16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0_FFFE, 1'b0, "sub_borrow");
        run_one(16'h8000, 16'h0001, 1'b0, 1'b1, 17'h1_7FFF, 1'b1, "sub_ovf");
        run_one(16'h0010, 16'h0010, 1'b1, 1'b1, 17'h1_0000, 1'b0, "sub_cin_ignored");
        tick();

        // Six back-to-back ops; output stalled during cycles 5..7.
        issued = 0; rcv = 0; held = '0;
        for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
            in_valid  = (issued < 6);
            a         = 16'hF000 + 16'(issued);
            b         = 16'h1000;
            cin       = 1'b0;
            sub       = 1'b0;
            out_ready = !(cyc >= 5 && cyc <= 7);
            #1;
            if (cyc >= 5 && cyc <= 7) begin
                check("stall_in_ready", in_ready, 0);
                check("stall_out_valid", out_valid, 1);
                if (cyc == 5) held = sum;
                else check("stall_sum_hold", sum, held);
            end
            if (out_valid && out_ready) begin
                check("stream_order", sum, 32'h1_0000 + rcv);
                rcv++;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) issued++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_received", rcv, 6);
        check("stream_issued", issued, 6);
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) extra++;
        end
        check("stream_no_dup", extra, 0);

        // Fill the pipe behind a stalled output, then reset mid-flight.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            a = 16'h0100 + 16'(i);
            b = 16'h0001;
            tick();
        end
        in_valid = 1'b0;
        check("pre_reset_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        check("reset_clears_valid", out_valid, 0);
        check("reset_clears_sum", sum, 0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) extra++;
        end
        check("no_stale_after_reset", extra, 0);
        run_one(16'h0001, 16'h0001, 1'b0, 1'b0, 17'h0_0002, 1'b0, "fresh_1_plus_1");
        tick();

        // Single-stage 8-bit build.
        check("s1_rst_valid", out_valid8, 0);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; sub8 = 1'b0; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        check("s1_latency_valid", out_valid8, 1);
        check("s1_sum_ff_ff_c1", sum8, 9'h1FF);
`ifdef PIPE_ADDER_OVF_EN
        check("s1_ovf", ovf8, 0);
`endif
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; sub8 = 1'b1; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        check("s1_sub_sum", sum8, 9'h0F0);
        tick();
        check("s1_drained", out_valid8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
